regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 82 ++++++++
 tb/tb_regfile_sb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write-back forwarding and a
// per-register pending scoreboard for in-flight producers.
module regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss,
  input  logic [AW-1:0]       isa,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  output logic [AW:0]         npend
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             wr_en;
  logic             is_en;
  logic [AW-1:0]    addr;

  assign wr_en = we && (wa != '0);
  assign is_en = iss && (isa != '0);

  // Scoreboard next state: flush, then write-back clear, then issue set (issue wins).
  always_comb begin
    pend_nxt = flush ? '0 : pend;
    if (wr_en) pend_nxt[wa] = 1'b0;
    if (is_en) pend_nxt[isa] = 1'b1;
    pend_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + CW'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pend  <= '0;
      npend <= '0;
    end else begin
      if (wr_en) regs[wa] <= wd;
      pend  <= pend_nxt;
      npend <= cnt_nxt;
    end
  end

  // Independent read ports; a same-cycle write-back forwards and hides its pending bit.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    addr  = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      addr = ra[k*AW +: AW];
      if (addr != '0) begin
        if ((BYPASS != 0) && wr_en && (wa == addr)) begin
          rd[k*XLEN +: XLEN] = wd;
          rbusy[k]           = 1'b0;
        end else begin
          rd[k*XLEN +: XLEN] = regs[addr];
          rbusy[k]           = pend[addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: forwarding and non-forwarding instances share stimulus
// and are checked against a bench-side register/scoreboard model.
module tb_regfile_sb;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                we, iss, flush;
  logic [AW-1:0]       wa, isa;
  logic [XLEN-1:0]     wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd_b1, rd_b0;
  logic [NRD-1:0]      rb_b1, rb_b0;
  logic [AW:0]         np_b1, np_b0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_b1 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .iss(iss), .isa(isa),
    .flush(flush), .ra(ra), .rd(rd_b1), .rbusy(rb_b1), .npend(np_b1));

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_b0 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .iss(iss), .isa(isa),
    .flush(flush), .ra(ra), .rd(rd_b0), .rbusy(rb_b0), .npend(np_b0));

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t            sbq[$];
  int              total = 0;
  int              bad   = 0;
  bit              armed = 1'b0;
  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_pend;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow observed=%0h expected=<entry>", obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] v);
    push(tag, v);
    pop_chk(obs);
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && we && (wa == a)) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_rb(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return 1'b0;
    if (byp && we && (wa == a)) return 1'b0;
    return m_pend[a];
  endfunction

  // Drive one cycle's inputs after the falling edge, then check combinational reads.
  task automatic drive(input bit rst_n, input bit w, input logic [AW-1:0] wa_i,
                       input logic [XLEN-1:0] wd_i, input bit is, input logic [AW-1:0] isa_i,
                       input bit fl, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    logic [AW-1:0] a;
    @(negedge clk);
    reset = rst_n; we = w; wa = wa_i; wd = wd_i;
    iss = is; isa = isa_i; flush = fl; ra = {r1, r0};
    #1;
    if (armed) begin
      for (int k = 0; k < NRD; k++) begin
        a = ra[k*AW +: AW];
        push($sformatf("rd_byp1_p%0d_a%0d", k, a), 64'(exp_rd(a, 1'b1)));
        push($sformatf("rd_byp0_p%0d_a%0d", k, a), 64'(exp_rd(a, 1'b0)));
        push($sformatf("rbusy_byp1_p%0d_a%0d", k, a), 64'(exp_rb(a, 1'b1)));
        push($sformatf("rbusy_byp0_p%0d_a%0d", k, a), 64'(exp_rb(a, 1'b0)));
      end
      for (int k = 0; k < NRD; k++) begin
        pop_chk(64'(rd_b1[k*XLEN +: XLEN]));
        pop_chk(64'(rd_b0[k*XLEN +: XLEN]));
        pop_chk(64'(rb_b1[k]));
        pop_chk(64'(rb_b0[k]));
      end
    end
  endtask

  // Clock edge: advance the model with the held inputs, then check npend.
  task automatic edge_chk();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_pend = '0;
      armed  = 1'b1;
    end else begin
      if (we && wa != '0) m_regs[wa] = wd;
      if (flush) m_pend = '0;
      if (we && wa != '0) m_pend[wa] = 1'b0;
      if (iss && isa != '0) m_pend[isa] = 1'b1;
    end
    #1;
    if (armed) begin
      push("npend_byp1", 64'($countones(m_pend)));
      push("npend_byp0", 64'($countones(m_pend)));
      pop_chk(64'(np_b1));
      pop_chk(64'(np_b0));
    end
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, r0, r1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; we = 1'b0; wa = '0; wd = '0; iss = 1'b0; isa = '0; flush = 1'b0; ra = '0;
    m_pend = '0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;

    // Two reset edges, then release with everything idle.
    repeat (2) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
      edge_chk();
    end
    idle(5'd5, 5'd31);
    chk("post_reset_rd", 64'(rd_b1), 64'(0));
    chk("post_reset_rbusy", 64'(rb_b1), 64'(0));
    chk("post_reset_npend", 64'(np_b1), 64'(0));
    edge_chk();

    // Forwarding on write-back vs. one-cycle-late visibility without it.
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, 5'd5, 5'd5);
    chk("fwd_same_cycle", 64'(rd_b1[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("nofwd_same_cycle", 64'(rd_b0[31:0]), 64'(0));
    edge_chk();
    idle(5'd5, 5'd0);
    chk("nofwd_next_cycle", 64'(rd_b0[31:0]), 64'h0000_0000_DEAD_BEEF);
    edge_chk();

    // Pending tracking: two producers, then retire one.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, '0); edge_chk();
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, '0, '0); edge_chk();
    idle(5'd0, 5'd3);
    chk("busy_r3", 64'(rb_b1[1]), 64'(1));
    chk("npend_two", 64'(np_b1), 64'(2));
    edge_chk();
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, '0, 1'b0, 5'd7, 5'd3);
    chk("busy_hidden_by_fwd", 64'(rb_b1[1]), 64'(0));
    chk("busy_seen_nofwd", 64'(rb_b0[1]), 64'(1));
    edge_chk();
    chk("npend_after_wb", 64'(np_b1), 64'(1));

    // Same-cycle issue and write-back to one register: issue wins.
    drive(1'b1, 1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 1'b0, '0, '0); edge_chk();
    idle(5'd9, 5'd9);
    chk("r9_data", 64'(rd_b0[31:0]), 64'h11);
    chk("r9_pending", 64'(rb_b0[0]), 64'(1));
    chk("npend_r7_r9", 64'(np_b1), 64'(2));
    edge_chk();

    // Re-issue of a pending register is not double counted.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0, '0); edge_chk();
    chk("npend_reissue", 64'(np_b1), 64'(2));

    // Write-back to a non-pending register leaves the scoreboard alone.
    drive(1'b1, 1'b1, 5'd10, 32'hA5A5_0010, 1'b0, '0, 1'b0, '0, '0); edge_chk();
    chk("npend_wb_nonpend", 64'(np_b1), 64'(2));

    // Flush with a same-cycle issue and write-back.
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd2, 1'b0, '0, '0); edge_chk();
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd4, 1'b0, '0, '0); edge_chk();
    drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd6, 1'b0, '0, '0); edge_chk();
    chk("npend_five", 64'(np_b1), 64'(5));
    drive(1'b1, 1'b1, 5'd12, 32'hC0DE, 1'b1, 5'd8, 1'b1, '0, '0); edge_chk();
    chk("npend_after_flush", 64'(np_b1), 64'(1));
    idle(5'd8, 5'd12);
    chk("flush_keeps_r8_busy", 64'(rb_b1[0]), 64'(1));
    chk("flush_write_r12", 64'(rd_b1[63:32]), 64'hC0DE);
    edge_chk();

    // Writes to register 0 are dropped, including through forwarding.
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 5'd0, 5'd0);
    chk("r0_fwd_zero", 64'(rd_b1[31:0]), 64'(0));
    edge_chk();
    idle(5'd0, 5'd0);
    chk("r0_stays_zero", 64'(rd_b1), 64'(0));
    chk("npend_r0_write", 64'(np_b1), 64'(1));
    edge_chk();

    // Populate regs 1..4 with pending producers, then reset mid-operation.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, AW'(i), XLEN'(32'h100 + i), 1'b1, AW'(i + 20), 1'b0, '0, '0);
      edge_chk();
    end
    drive(1'b0, 1'b1, 5'd1, 32'hBAD, 1'b1, 5'd2, 1'b1, 5'd1, 5'd2);
    edge_chk();
    chk("npend_after_reset", 64'(np_b1), 64'(0));
    for (int i = 1; i <= 4; i += 2) begin
      idle(AW'(i), AW'(i + 1));
      chk($sformatf("reset_clears_r%0d", i), 64'(rd_b1), 64'(0));
      edge_chk();
    end

    // Randomised traffic against the model, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 1) == 1), AW'($urandom()),
            XLEN'($urandom()), ($urandom_range(0, 2) == 0), AW'($urandom()),
            ($urandom_range(0, 19) == 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      edge_chk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
